// File: rtl/prg_loader.sv
// prg_loader: turns a VIC-20 .PRG byte stream from the download block into
// RAM writes. The first two file bytes are the load address. At the end of
// the file the BASIC VARTAB/ARYTAB/STREND pointers are patched to the end address.
module prg_loader #(
  parameter logic [4:0] PRG_INDEX = 5'd1,
  parameter bit         PATCH_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        downloading,
  input  logic [4:0]  dl_index,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        ram_req,
  input  logic        ram_ack,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_dout,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_LO,
    S_HDR_HI,
    S_DATA,
    S_WAIT,
    S_PATCH
  } state_t;

  state_t      state, state_nxt;
  logic        dl_q;
  logic        rise, fall;
  logic [15:0] load_addr;
  logic [15:0] cnt;
  logic [15:0] end_addr;
  logic [2:0]  patch_idx;

  logic        start;
  logic        load_lo;
  logic        load_hi;
  logic        take_byte;
  logic        set_ovr;
  logic        patch_issue;
  logic        patch_ack;
  logic        finish;

  assign rise     = downloading & ~dl_q;
  assign fall     = ~downloading & dl_q;
  // Target of the next data byte; once the file is over this is also the end address.
  assign end_addr = load_addr + cnt;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and the one-cycle control strobes that drive the datapath.
  always_comb begin
    state_nxt   = state;
    start       = 1'b0;
    load_lo     = 1'b0;
    load_hi     = 1'b0;
    take_byte   = 1'b0;
    set_ovr     = 1'b0;
    patch_issue = 1'b0;
    patch_ack   = 1'b0;
    finish      = 1'b0;
    case (state)
      S_IDLE: begin
        if (rise && dl_index == PRG_INDEX) begin
          start     = 1'b1;
          state_nxt = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (fall) begin
          finish    = 1'b1;
          state_nxt = S_IDLE;
        end else if (dl_wr) begin
          load_lo   = 1'b1;
          state_nxt = S_HDR_HI;
        end
      end
      S_HDR_HI: begin
        if (fall) begin
          finish    = 1'b1;
          state_nxt = S_IDLE;
        end else if (dl_wr) begin
          load_hi   = 1'b1;
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (fall) begin
          // A header-only file carries no program, so it gets no patch either.
          if (cnt == 16'd0) begin
            finish    = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_WAIT;
          end
        end else if (dl_wr) begin
          if (ram_req || dl_addr != ({9'd0, cnt} + 25'd2)) set_ovr = 1'b1;
          if (!ram_req) take_byte = 1'b1;
        end
      end
      S_WAIT: begin
        if (dl_wr) set_ovr = 1'b1;
        if (!ram_req) begin
          if (PATCH_EN) begin
            state_nxt = S_PATCH;
          end else begin
            finish    = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_PATCH: begin
        if (dl_wr) set_ovr = 1'b1;
        if (!ram_req) begin
          patch_issue = 1'b1;
        end else if (ram_ack) begin
          patch_ack = 1'b1;
          if (patch_idx == 3'd5) begin
            finish    = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: edge detect, header capture, RAM handshake, patch sequencing and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      dl_q      <= 1'b0;
      load_addr <= 16'd0;
      cnt       <= 16'd0;
      patch_idx <= 3'd0;
      ram_req   <= 1'b0;
      ram_addr  <= 16'd0;
      ram_dout  <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      dl_q <= downloading;
      done <= finish;

      if (start) begin
        busy      <= 1'b1;
        overrun   <= 1'b0;
        cnt       <= 16'd0;
        patch_idx <= 3'd0;
      end else if (set_ovr) begin
        overrun <= 1'b1;
      end
      if (finish) busy <= 1'b0;

      if (load_lo) load_addr[7:0]  <= dl_data;
      if (load_hi) load_addr[15:8] <= dl_data;

      if (ram_req && ram_ack) ram_req <= 1'b0;
      if (patch_ack) patch_idx <= patch_idx + 3'd1;

      if (take_byte) begin
        ram_addr <= end_addr;
        ram_dout <= dl_data;
        ram_req  <= 1'b1;
        cnt      <= cnt + 16'd1;
      end

      // Even patch slots take the low byte of the end address, odd slots the high byte.
      if (patch_issue) begin
        ram_addr <= 16'h002D + {13'd0, patch_idx};
        ram_dout <= patch_idx[0] ? end_addr[15:8] : end_addr[7:0];
        ram_req  <= 1'b1;
      end
    end
  end

endmodule
